bcd_counter_core: RTL
=====================

Name: bcd_counter_core

Overview:
- Multi-digit decimal (BCD) up/down counter placed directly downstream of the clock divider.
- Advances exactly once per cycle in which the divider's single-cycle enable pulse (tick) is high.
- Presents packed BCD digits to the display/top level.
- Raises a registered wrap pulse so counters can be cascaded.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  count enable pulse from the clock divider; one clk wide.
- en  input  1  count gate; tick ignored when 0.
- up_dn  input  1  1 = count up, 0 = count down; sampled on the counting edge.
- clear  input  1  synchronous clear to all zeros.
- load  input  1  synchronous parallel load.
- load_value  input  4*NUM_DIGITS  packed BCD load data; digit i at bits [4i+3:4i].
- bcd  output  4*NUM_DIGITS  packed BCD count; same packing as load_value.
- wrap  output  1  one-cycle pulse on a 99..9->0 or 0->99..9 roll.
- at_zero  output  1  high when the count is all zeros.
- at_max  output  1  high when every digit is 9.

Behaviour:
- Reset (rst=0, asynchronous, regardless of clk):
  - bcd=0, wrap=0, at_zero=1, at_max=0.
  - Release is synchronous to the next clk edge; no count occurs on the release edge unless tick=1 and en=1.
- Per-edge priority, highest first:
  - clear.
  - load.
  - count, when tick=1 and en=1.
  - hold.
- clear=1: bcd becomes 0 on that edge; wrap=0.
- load=1 and clear=0:
  - bcd takes load_value on that edge; wrap=0.
  - Any load nibble >9 is stored as 0; other digits load unchanged.
  - A load and a tick on the same edge result in the load value with no increment.
- Count up:
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit; ripple is resolved combinationally within the same edge.
  - All digits 9 -> all zeros, with wrap=1 for exactly the following cycle.
- Count down:
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - All zeros -> all nines, with wrap=1 for the following cycle.
- Latency: a tick sampled on edge N is visible on bcd, at_zero, at_max and wrap after edge N (one-cycle registered latency); all outputs are registers.
- wrap is 0 on every edge that does not perform a rolling count.
- en=0 or tick=0: bcd holds; wrap=0.
- Flags:
  - at_zero and at_max are registered to match bcd after each edge, never derived combinationally from stale state.
  - at_zero is recomputed after clear/load.
- Digit invariant: every stored digit is 0..9 at all times; no state reachable from reset or load holds a digit >9.
- Reset mid-operation: asynchronous reset overrides any in-progress count, load or wrap pulse immediately.

Decomposition:
- Shared package holds BCD_MAX (4'd9), BCD_ZERO (4'd0) and a function to validate or sanitise a nibble.
- Natural sub-module: bcd_digit, one per digit, generated NUM_DIGITS times.
  - Inputs: step enable, direction, load enable, load nibble, clear.
  - Outputs: nibble, carry/borrow out.
  - The top chains carry_out into the next digit's step enable.
- The top adds wrap, at_zero and at_max registers.

Test Plan:
1. Reset behaviour: rst=0 mid-count with bcd=0x0042 -> bcd=0x0000, at_zero=1, wrap=0 immediately, without waiting for a clk edge.
2. Up-count with carry: load 0x0199, up_dn=1, one tick -> bcd=0x0200, wrap=0; a tick with en=0 -> bcd unchanged.
3. Up wrap: load 0x9999, up_dn=1, tick -> bcd=0x0000, wrap=1 for exactly one cycle, at_zero=1, at_max=0.
4. Down wrap and borrow: load 0x1000, up_dn=0, tick -> 0x0999; then load 0x0000 and tick -> 0x9999, wrap=1, at_max=1.
5. Priority: clear=1, load=1 (0x1234) and tick=1 on the same edge -> 0x0000; then load=1 (0x1234) with tick=1 -> 0x1234, not 0x1235.
6. Invalid load: load_value=0x1A3F -> bcd=0x1030; then two up ticks -> 0x1032.

Source files
------------

// File: rtl/bcd_counter_core_pkg.sv
// Shared constants and nibble helpers for the BCD counter core.
// Imported by the digit slice and the top level.
package bcd_counter_core_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Any nibble outside 0..9 becomes zero, so loaded data cannot create an illegal digit.
    function automatic logic [3:0] sanitise_nibble(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_ZERO : nibble;
    endfunction

endpackage

// File: rtl/bcd_counter_core_if.sv
// Control and status bundle of the BCD counter core.
// The master drives the controls; the counter (slave) returns the count and the flags.
interface bcd_counter_core_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    tick;
    logic                    en;
    logic                    up_dn;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    wrap;
    logic                    at_zero;
    logic                    at_max;

    modport master (
        output tick, en, up_dn, clear, load, load_value,
        input  bcd, wrap, at_zero, at_max
    );

    modport slave (
        input  tick, en, up_dn, clear, load, load_value,
        output bcd, wrap, at_zero, at_max
    );

endinterface

// File: rtl/bcd_counter_core_digit.sv
// One decimal digit: clear > load > step, with a carry/borrow output that
// feeds the step input of the next more significant digit.
module bcd_digit
    import bcd_counter_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_nibble,
    input  logic       clear,
    output logic [3:0] nibble,
    output logic [3:0] nibble_next,
    output logic       carry
);

    always_comb begin
        // NOTE: the hold value is assigned first so every path writes nibble_next; no latch is inferred.
        nibble_next = nibble;
        if (clear) begin
            nibble_next = BCD_ZERO;
        end else if (load) begin
            nibble_next = sanitise_nibble(load_nibble);
        end else if (step) begin
            if (up_dn) begin
                nibble_next = (nibble == BCD_MAX) ? BCD_ZERO : nibble + 4'd1;
            end else begin
                nibble_next = (nibble == BCD_ZERO) ? BCD_MAX : nibble - 4'd1;
            end
        end
    end

    // A digit only rolls on a real count edge, never while being cleared or loaded.
    assign carry = step && !clear && !load &&
                   (up_dn ? (nibble == BCD_MAX) : (nibble == BCD_ZERO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nibble <= BCD_ZERO;
        end else begin
            // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
            nibble <= nibble_next;
        end
    end

endmodule

// File: rtl/bcd_counter_core.sv
// Multi-digit BCD up/down counter with registered wrap, at_zero and at_max flags.
// Digits ripple their carry/borrow combinationally within one tick edge.
module bcd_counter_core
    import bcd_counter_core_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_counter_core_if.slave      bus
);

    logic [NUM_DIGITS:0]     step_chain;
    logic [4*NUM_DIGITS-1:0] bcd_next;
    logic                    at_zero_next;
    logic                    at_max_next;

    assign step_chain[0] = bus.tick & bus.en;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk         (clk),
            .rst         (rst),
            .step        (step_chain[i]),
            .up_dn       (bus.up_dn),
            .load        (bus.load),
            .load_nibble (bus.load_value[4*i +: 4]),
            .clear       (bus.clear),
            .nibble      (bus.bcd[4*i +: 4]),
            .nibble_next (bcd_next[4*i +: 4]),
            .carry       (step_chain[i+1])
        );
    end

    // Flags are computed from the value the digits are about to store, so they track bcd exactly.
    assign at_zero_next = (bcd_next == '0);
    assign at_max_next  = (bcd_next == {NUM_DIGITS{BCD_MAX}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wrap    <= 1'b0;
            bus.at_zero <= 1'b1;
            bus.at_max  <= 1'b0;
        end else begin
            bus.wrap    <= step_chain[NUM_DIGITS];
            bus.at_zero <= at_zero_next;
            bus.at_max  <= at_max_next;
        end
    end

endmodule
